// File: rtl/seg_pkg.sv
// Shared types and constants for the serial seven-segment driver: FSM states, blank byte, glyph table.
// Pure declarations; no logic, no latency, no flow control.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } seg_state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low g..a glyphs, entry n at index n; bit7 (dp) is off here.
    localparam logic [15:0][7:0] SEG_GLYPH = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/hex_to_seg.sv
// Nibble plus decimal-point request to an active-low segment byte {dp, g..a}.
// Purely combinational, zero latency, no flow control.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = {~dp_i, SEG_GLYPH[nib_i][6:0]};

endmodule

// File: rtl/seg7_serial_drv.sv
// Eight-digit serial 7-seg refresher; optional digit blinking under SEG_BLINK_EN.
// Frame = 2 + 129*CLK_DIV cycles, free-running, inputs snapshotted at LOAD; no backpressure.
module seg7_serial_drv
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int BLINK_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  point_in,
    input  logic [7:0]  LE_in,
    output logic        seg_clk,
    output logic        seg_sout,
    output logic        seg_pen,
    output logic        seg_clrn,
    output logic        busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [7:0]  blank_mask;
    logic [63:0] frame_d;

`ifdef SEG_BLINK_EN
    logic [BLINK_W-1:0] blink_q;
    logic [BLINK_W-1:0] blink_d;

    assign blink_d = blink_q + BLINK_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blank_mask = blink_q[BLINK_W-1] ? LE_in : 8'h00;
`else
    logic unused_le;
    localparam int unused_blink_w = BLINK_W;

    assign unused_le  = ^LE_in;
    assign blank_mask = 8'h00;
`endif

    // Digit 7 occupies the top byte so it leaves the shift register first.
    for (genvar i = 0; i < 8; i++) begin : g_digit
        logic [7:0] seg;

        hex_to_seg u_dec (
            .nib_i (Disp_num[4*i +: 4]),
            .dp_i  (point_in[i]),
            .seg_o (seg)
        );

        assign frame_d[8*i +: 8] = blank_mask[i] ? SEG_BLANK : seg;
    end

    seg_state_e       state_q;
    logic [62:0]      sr_q;
    logic [5:0]       bit_cnt_q;
    logic             bit_last_q;
    logic [DIV_W-1:0] div_q;
    logic             half_q;
    logic             seg_clk_q;
    logic             seg_sout_q;
    logic             seg_pen_q;
    logic             seg_clrn_q;
    logic             busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '1;
            bit_cnt_q  <= '0;
            bit_last_q <= 1'b0;
            div_q      <= '0;
            half_q     <= 1'b0;
            seg_clk_q  <= 1'b0;
            seg_sout_q <= 1'b1;
            seg_pen_q  <= 1'b0;
            seg_clrn_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            seg_clrn_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    state_q <= LOAD;
                    busy_q  <= 1'b1;
                end
                LOAD: begin
                    // Bit 63 goes straight to the pin; the register holds the rest.
                    sr_q       <= frame_d[62:0];
                    seg_sout_q <= frame_d[63];
                    bit_cnt_q  <= '0;
                    bit_last_q <= 1'b0;
                    div_q      <= '0;
                    half_q     <= 1'b0;
                    state_q    <= SHIFT;
                end
                SHIFT: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        if (!half_q) begin
                            half_q    <= 1'b1;
                            seg_clk_q <= 1'b1;
                        end else begin
                            half_q    <= 1'b0;
                            seg_clk_q <= 1'b0;
                            if (bit_last_q) begin
                                state_q   <= LATCH;
                                seg_pen_q <= 1'b1;
                            end else begin
                                sr_q       <= {sr_q[61:0], 1'b0};
                                seg_sout_q <= sr_q[62];
                                bit_cnt_q  <= bit_cnt_q + 6'd1;
                                bit_last_q <= (bit_cnt_q == 6'd62);
                            end
                        end
                    end
                end
                LATCH: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q     <= '0;
                        seg_pen_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign seg_clk  = seg_clk_q;
    assign seg_sout = seg_sout_q;
    assign seg_pen  = seg_pen_q;
    assign seg_clrn = seg_clrn_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_seg7_serial_drv.sv
// Scoreboard bench: expected segment bytes queued at each LOAD, popped as the serial link delivers them.
`timescale 1ns/1ps
module tb_seg7_serial_drv;

    localparam int D0 = 2;
    localparam int D1 = 1;
    localparam int BW = 10;
`ifdef SEG_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] disp_num = 32'h01234567;
    logic [7:0]  point_in = 8'h00;
    logic [7:0]  le_in    = 8'h00;

    logic s0_clk, s0_sout, s0_pen, s0_clrn, s0_busy;
    logic s1_clk, s1_sout, s1_pen, s1_clrn, s1_busy;

    always #5 clk = ~clk;

    seg7_serial_drv #(.CLK_DIV(D0), .BLINK_W(BW)) dut0 (
        .clk(clk), .rst(rst), .Disp_num(disp_num), .point_in(point_in), .LE_in(le_in),
        .seg_clk(s0_clk), .seg_sout(s0_sout), .seg_pen(s0_pen), .seg_clrn(s0_clrn), .busy(s0_busy)
    );

    seg7_serial_drv #(.CLK_DIV(D1), .BLINK_W(24)) dut1 (
        .clk(clk), .rst(rst), .Disp_num(disp_num), .point_in(point_in), .LE_in(le_in),
        .seg_clk(s1_clk), .seg_sout(s1_sout), .seg_pen(s1_pen), .seg_clrn(s1_clrn), .busy(s1_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [3:0] n, input logic dp,
                                            input logic le, input logic ph);
        logic [7:0] b;
        b = GLYPH[n];
        if (dp) b[7] = 1'b0;
        if (BLINK_ON && le && ph) b = 8'hFF;
        return b;
    endfunction

    // Reference blink counter: reset to 0, +1 every cycle.
    logic [BW-1:0] tb_blink = '0;
    always @(posedge clk) tb_blink <= rst ? '0 : tb_blink + BW'(1);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0 receiver / scoreboard
    logic [7:0] q0 [$];
    logic [7:0] rx0_sr = '0;
    int  rx0_bits = 0, pen0_w = 0, ll0 = -1;
    logic p0_clk = 1'b0, p0_sout = 1'b1, p0_busy = 1'b0, p0_pen = 1'b0;
    logic hi0_cap = 1'b0, hi0_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            rx0_bits = 0; pen0_w = 0; ll0 = -1;
            p0_clk = 1'b0; p0_sout = 1'b1; p0_busy = 1'b0; p0_pen = 1'b0;
        end else begin
            if (s0_busy && !p0_busy) begin
                if (ll0 >= 0) check("frame_len0", 32'(cyc - ll0), 32'(2 + 129*D0));
                ll0 = cyc;
                for (int d = 7; d >= 0; d--)
                    q0.push_back(exp_byte(disp_num[4*d +: 4], point_in[d], le_in[d], tb_blink[BW-1]));
                rx0_bits = 0;
            end
            if (s0_clk && !p0_clk) begin
                check("setup0", 32'(s0_sout), 32'(p0_sout));
                rx0_sr  = {rx0_sr[6:0], s0_sout};
                rx0_bits++;
                hi0_cap = s0_sout;
                if (rx0_bits % 8 == 0) begin
                    check("q0_depth", 32'(q0.size() != 0), 32'd1);
                    if (q0.size() != 0) check("byte0", 32'(rx0_sr), 32'(q0.pop_front()));
                end
            end
            if (s0_clk) hi0_last = s0_sout;
            if (!s0_clk && p0_clk) check("hold0", 32'(hi0_last), 32'(hi0_cap));
            if (s0_pen) begin
                pen0_w++;
                check("pen_clk0", 32'(s0_clk), 32'd0);
            end
            if (!s0_pen && p0_pen) begin
                check("pen_w0", 32'(pen0_w), 32'(D0));
                check("pen_bits0", 32'(rx0_bits), 32'd64);
                pen0_w = 0;
            end
            p0_clk = s0_clk; p0_sout = s0_sout; p0_busy = s0_busy; p0_pen = s0_pen;
        end
    end

    // dut1 (CLK_DIV=1): frame length, setup, first byte, latch width
    logic [7:0] rx1_sr = '0, exp1 = '0;
    int  rx1_bits = 0, pen1_w = 0, ll1 = -1;
    logic p1_clk = 1'b0, p1_sout = 1'b1, p1_busy = 1'b0, p1_pen = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            rx1_bits = 0; pen1_w = 0; ll1 = -1;
            p1_clk = 1'b0; p1_sout = 1'b1; p1_busy = 1'b0; p1_pen = 1'b0;
        end else begin
            if (s1_busy && !p1_busy) begin
                if (ll1 >= 0) check("frame_len1", 32'(cyc - ll1), 32'(2 + 129*D1));
                ll1 = cyc;
                exp1 = exp_byte(disp_num[31:28], point_in[7], le_in[7], 1'b0);
                rx1_bits = 0;
            end
            if (s1_clk && !p1_clk) begin
                check("setup1", 32'(s1_sout), 32'(p1_sout));
                rx1_sr = {rx1_sr[6:0], s1_sout};
                rx1_bits++;
                if (rx1_bits == 8) check("byte7_1", 32'(rx1_sr), 32'(exp1));
            end
            if (s1_pen) pen1_w++;
            if (!s1_pen && p1_pen) begin
                check("pen_w1", 32'(pen1_w), 32'(D1));
                check("pen_bits1", 32'(rx1_bits), 32'd64);
                pen1_w = 0;
            end
            p1_clk = s1_clk; p1_sout = s1_sout; p1_busy = s1_busy; p1_pen = s1_pen;
        end
    end

    task automatic wait_loads(input int n);
        logic prev, found;
        for (int k = 0; k < n; k++) begin
            prev  = s0_busy;
            found = 1'b0;
            for (int c = 0; c < 1000 && !found; c++) begin
                @(negedge clk);
                if (s0_busy && !prev) found = 1'b1;
                prev = s0_busy;
            end
            if (!found) check("load_timeout", 32'(found), 32'd1);
        end
    endtask

    task automatic wait_bits(input int n);
        logic prev;
        int   seen;
        prev = s0_clk;
        seen = 0;
        for (int c = 0; c < 1000 && seen < n; c++) begin
            @(negedge clk);
            if (s0_clk && !prev) seen++;
            prev = s0_clk;
        end
        if (seen < n) check("bit_timeout", 32'(seen), 32'(n));
    endtask

    task automatic set_inputs(input logic [31:0] d, input logic [7:0] p, input logic [7:0] l);
        @(posedge clk);
        #1;
        disp_num = d;
        point_in = p;
        le_in    = l;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_clk",  32'(s0_clk),  32'd0);
        check("rst_sout", 32'(s0_sout), 32'd1);
        check("rst_pen",  32'(s0_pen),  32'd0);
        check("rst_clrn", 32'(s0_clrn), 32'd0);
        check("rst_busy", 32'(s0_busy), 32'd0);
        check("rst_busy1", 32'(s1_busy), 32'd0);

        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(s0_busy), 32'd0);
        @(negedge clk);
        check("load_busy", 32'(s0_busy), 32'd1);
        check("load_clrn", 32'(s0_clrn), 32'd1);

        wait_loads(2);
        set_inputs(32'h01234567, 8'h80, 8'h00);
        wait_loads(3);
        set_inputs(32'h01234567, 8'h80, 8'h01);
        wait_loads(9);
        set_inputs(32'h00000000, 8'h00, 8'h00);
        wait_loads(2);
        wait_bits(20);
        set_inputs(32'hFFFFFFFF, 8'h00, 8'h00);
        wait_loads(3);

        wait_bits(30);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_clk",  32'(s0_clk),  32'd0);
        check("abort_pen",  32'(s0_pen),  32'd0);
        check("abort_clrn", 32'(s0_clrn), 32'd0);
        check("abort_busy", 32'(s0_busy), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("restart_idle", 32'(s0_busy), 32'd0);
        check("restart_pen",  32'(s0_pen),  32'd0);
        @(negedge clk);
        check("restart_load", 32'(s0_busy), 32'd1);

        set_inputs(32'h89ABCDEF, 8'h55, 8'h00);
        wait_loads(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
